mem_if_u: RTL and testbench
===========================

// Module: mem_if_u
// PURPOSE
//  Bus-attached memory interface (MAR + MDR + access sequencer) on the shared tri-state CPU bus.
//  - Consumes addresses the PC (or any unit) places on the bus: MARin latches the address.
//  - Runs a req/ack memory transaction, so the fetched instruction or data can be put back on the bus.
//  - Sits directly downstream of PC_u in the fetch path, and is driven by the same control unit.
// PARAMETERS
//  w       32   bus / address / data width
//  TO_CYC  15   cycles a transaction may wait for mem_ack before abort (>=1)
// PORTS
//  clk        in     1  system clock, all state on posedge
//  rst        in     1  reset, asynchronous, active-high
//  bus        inout  w  shared tri-state CPU bus
//  MARin      in     1  latch bus into MAR
//  MDRin      in     1  latch bus into MDR
//  MDRout     in     1  drive MDR onto bus
//  Read       in     1  start read:  MDR <= mem[MAR]
//  Write      in     1  start write: mem[MAR] <= MDR
//  busy       out    1  transaction in progress
//  done       out    1  1-cycle pulse on successful completion
//  err        out    1  sticky timeout flag
//  mem_addr   out    w  memory address (= MAR)
//  mem_wdata  out    w  write data (= MDR)
//  mem_rdata  in     w  read data, valid when mem_ack=1
//  mem_req    out    1  request, held until ack or timeout
//  mem_we     out    1  1 = write, 0 = read; valid while mem_req=1
//  mem_ack    in     1  memory completion, sampled on posedge
// BEHAVIOUR
//  Reset (async, immediate, also mid-transaction)
//  - MAR=0, MDR=0, state IDLE, counter=0.
//  - mem_req=0, mem_we=0, busy=0, done=0, err=0.
//  - bus released ('z'). A pending transaction is dropped and no done pulse is issued.
//  Bus drive
//  - bus = MDRout ? MDR : 'z. Combinational, in any state.
//  - While Read is busy, the bus carries the old MDR.
//  Register loads (posedge, IDLE only)
//  - MARin: MAR<=bus. MDRin: MDR<=bus.
//  - In RD/WR both are ignored, so MAR and MDR stay stable during a transaction.
//  - mem_addr=MAR and mem_wdata=MDR continuously.
//  FSM: IDLE, RD, WR
//  IDLE
//  - Read=1 -> RD: mem_req=1, mem_we=0, counter=0, err cleared.
//  - Write=1 -> WR: mem_req=1, mem_we=1, counter=0, err cleared.
//  - Read and Write together: Read wins and Write is discarded.
//  - MDRin together with Read: MDR loads the bus value now and is overwritten later by the read data.
//  - MARin together with Read/Write: the transaction uses the OLD MAR.
//  RD/WR, on each posedge
//  - mem_ack=1: RD latches MDR<=mem_rdata; mem_req<=0; done=1 for exactly one cycle; go to IDLE.
//  - else if counter==TO_CYC-1: mem_req<=0; err<=1; no done; MDR unchanged; go to IDLE.
//  - else: counter++.
//  busy = (state != IDLE).
//  Timing
//  - Read/Write sampled at edge N -> mem_req high after edge N.
//  - Ack sampled at edge N+k (k>=1) -> done high for the cycle after edge N+k.
//  - The next command is accepted at edge N+k+1.
//  Ignored inputs
//  - Read/Write while busy.
//  - mem_ack while IDLE.
//  - err stays set until the next accepted Read/Write.
// STRUCTURE
//  - Shared package cpu_pkg: parameter W=32; typedef enum logic[1:0] {MEM_IDLE, MEM_RD, MEM_WR} mem_state_t.
//  - One FSM always_ff, plus the counter sized $clog2(TO_CYC+1).
//  - Sub-module tri_drv #(w) (en, d, bus) for the bus driver, shared with PC_u/IR-style bus registers.
// TESTING
//  1. rst high 2 cycles, then low -> all outputs 0, bus 'z', MDRout=1 reads 0.
//  2. bus=0x10 + MARin, then bus=0xDEADBEEF + MDRin -> mem_addr=0x10; MDRout=1 gives bus=0xDEADBEEF.
//  3. Read with ack after 3 cycles, rdata=0x12345678
//     -> mem_req high 3 cycles with mem_we=0; done 1 cycle; MDRout gives 0x12345678.
//  4. Write with MDR=0xA5A5A5A5 and ack on the first cycle
//     -> mem_we=1, mem_wdata=0xA5A5A5A5; done one cycle after req; busy 1 cycle.
//  5. Read with no ack -> req drops after exactly 15 cycles; err=1; done=0; MDR unchanged; next Read clears err.
//  6. Read+Write same cycle -> mem_we=0. MARin=0x40 while busy -> MAR unchanged.
//     rst asserted mid-read -> mem_req=0 immediately and no done.

Source files
------------

// File: rtl/mem_if_u_pkg.sv
// Shared definitions for the bus-attached memory interface: data width and sequencer states.
package mem_if_u_pkg;

    localparam int W = 32;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_RD,
        MEM_WR
    } mem_state_t;

endpackage

// File: rtl/mem_if_u_if.sv
// Memory-side request/acknowledge handshake between mem_if_u (master) and the memory (slave).
interface mem_if_u_if
    import mem_if_u_pkg::*;
#(
    parameter int WIDTH = W
);

    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_req;
    logic             mem_we;
    logic             mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_req, mem_we,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_req, mem_we,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_if_u_tri_drv.sv
// Tri-state driver used by every register that can put its value onto the shared CPU bus.
module tri_drv #(
    parameter int w = 32
) (
    input  logic         en,
    input  logic [w-1:0] d,
    inout  wire  [w-1:0] bus
);

    assign bus = en ? d : {w{1'bz}};

endmodule

// File: rtl/mem_if_u.sv
// MAR/MDR pair plus a req/ack access sequencer with timeout, attached to the shared CPU bus.
module mem_if_u
    import mem_if_u_pkg::*;
#(
    parameter int w      = W,
    parameter int TO_CYC = 15
) (
    input  logic         clk,
    input  logic         rst,
    inout  wire  [w-1:0] bus,
    input  logic         MARin,
    input  logic         MDRin,
    input  logic         MDRout,
    input  logic         Read,
    input  logic         Write,
    output logic         busy,
    output logic         done,
    output logic         err,
    mem_if_u_if.master   mem
);

    localparam int CW = $clog2(TO_CYC + 1);

    mem_state_t    state;
    logic [w-1:0]  mar;
    logic [w-1:0]  mdr;
    logic [CW-1:0] count;
    logic          req;
    logic          we;

    // A MAR load coinciding with an accepted command is dropped so the access
    // keeps the old address and mem_addr always equals MAR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MEM_IDLE;
            mar   <= '0;
            mdr   <= '0;
            count <= '0;
            req   <= 1'b0;
            we    <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (MDRin) mdr <= bus;
                    if (MARin && !Read && !Write) mar <= bus;
                    if (Read) begin
                        state <= MEM_RD;
                        req   <= 1'b1;
                        we    <= 1'b0;
                        count <= '0;
                        err   <= 1'b0;
                    end else if (Write) begin
                        state <= MEM_WR;
                        req   <= 1'b1;
                        we    <= 1'b1;
                        count <= '0;
                        err   <= 1'b0;
                    end
                end
                MEM_RD, MEM_WR: begin
                    if (mem.mem_ack) begin
                        if (state == MEM_RD) mdr <= mem.mem_rdata;
                        req   <= 1'b0;
                        we    <= 1'b0;
                        done  <= 1'b1;
                        state <= MEM_IDLE;
                    end else if (count == CW'(TO_CYC - 1)) begin
                        req   <= 1'b0;
                        we    <= 1'b0;
                        err   <= 1'b1;
                        state <= MEM_IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
    end

    assign busy          = (state != MEM_IDLE);
    assign mem.mem_addr  = mar;
    assign mem.mem_wdata = mdr;
    assign mem.mem_req   = req;
    assign mem.mem_we    = we;

    tri_drv #(.w(w)) u_mdr_drv (
        .en  (MDRout),
        .d   (mdr),
        .bus (bus)
    );

endmodule

// File: tb/tb_mem_if_u.sv
// Randomised bench for mem_if_u against a transaction-level model of MAR, MDR and err.
module tb_mem_if_u;
    import mem_if_u_pkg::*;

    localparam int TO_CYC = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MARin = 1'b0, MDRin = 1'b0, MDRout = 1'b0, Read = 1'b0, Write = 1'b0;
    logic        busy, done, err;
    logic        tb_bus_en = 1'b0;
    logic [31:0] tb_bus_val = '0;
    wire  [31:0] bus;

    int tests_run  = 0;
    int fail_count = 0;

    logic [31:0] exp_mar = '0;
    logic [31:0] exp_mdr = '0;
    logic        exp_err = 1'b0;

    mem_if_u_if #(.WIDTH(32)) mem ();

    assign bus = tb_bus_en ? tb_bus_val : 'z;

    mem_if_u #(.w(32), .TO_CYC(TO_CYC)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .MARin  (MARin),
        .MDRin  (MDRin),
        .MDRout (MDRout),
        .Read   (Read),
        .Write  (Write),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .mem    (mem.master)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reads MDR through the bus, then confirms the DUT lets go of the bus.
    task automatic readMdr();
        tb_bus_en = 1'b0;
        MDRout    = 1'b1;
        #1;
        checkOutput("mdr_on_bus", bus, exp_mdr);
        MDRout     = 1'b0;
        tb_bus_val = ~exp_mdr;
        tb_bus_en  = 1'b1;
        #1;
        checkOutput("bus_released", bus, ~exp_mdr);
        tb_bus_en = 1'b0;
    endtask

    // Idle-cycle register load; optional mem_ack noise must be ignored.
    task automatic applyStimulus(input bit mar_ld, input bit mdr_ld, input logic [31:0] val, input bit ack_noise);
        tb_bus_en    = 1'b1;
        tb_bus_val   = val;
        MARin        = mar_ld;
        MDRin        = mdr_ld;
        mem.mem_ack  = ack_noise;
        mem.mem_rdata = $urandom;
        @(negedge clk);
        MARin       = 1'b0;
        MDRin       = 1'b0;
        tb_bus_en   = 1'b0;
        mem.mem_ack = 1'b0;
        if (mar_ld) exp_mar = val;
        if (mdr_ld) exp_mdr = val;
        checkOutput("idle_addr", mem.mem_addr, exp_mar);
        checkOutput("idle_wdata", mem.mem_wdata, exp_mdr);
        checkOutput("idle_busy", {31'b0, busy}, 32'd0);
        checkOutput("idle_done", {31'b0, done}, 32'd0);
        checkOutput("idle_err", {31'b0, err}, {31'b0, exp_err});
    endtask

    // One command; d is the cycle on which ack arrives (d > TO_CYC means never).
    task automatic doTransaction(input bit rd, input bit wr, input int d, input bit mar_ld,
                                 input bit mdr_ld, input logic [31:0] bus_val, input logic [31:0] rd_val);
        bit is_read;
        int exp_cycles;
        int count;
        is_read    = rd;
        exp_cycles = (d <= TO_CYC) ? d : TO_CYC;
        tb_bus_en  = mar_ld | mdr_ld;
        tb_bus_val = bus_val;
        MARin = mar_ld;
        MDRin = mdr_ld;
        Read  = rd;
        Write = wr;
        @(negedge clk);
        Read = 1'b0; Write = 1'b0; MARin = 1'b0; MDRin = 1'b0; tb_bus_en = 1'b0;
        if (mdr_ld) exp_mdr = bus_val;
        exp_err = 1'b0;
        count = 0;
        while (mem.mem_req === 1'b1 && count < 40) begin
            checkOutput("busy_mid", {31'b0, busy}, 32'd1);
            checkOutput("we_mid", {31'b0, mem.mem_we}, is_read ? 32'd0 : 32'd1);
            checkOutput("addr_mid", mem.mem_addr, exp_mar);
            checkOutput("err_cleared", {31'b0, err}, 32'd0);
            checkOutput("done_mid", {31'b0, done}, 32'd0);
            if (!is_read) checkOutput("wdata_mid", mem.mem_wdata, exp_mdr);
            count++;
            mem.mem_ack   = (count == d);
            mem.mem_rdata = (count == d) ? rd_val : $urandom;
            if (count == 1 && is_read) begin
                MDRout = 1'b1;
                #1;
                checkOutput("old_mdr_on_bus", bus, exp_mdr);
                MDRout = 1'b0;
            end else if (count >= 2) begin
                tb_bus_en  = 1'b1;
                tb_bus_val = $urandom;
                MARin = 1'b1;
                MDRin = 1'b1;
            end
            @(negedge clk);
            MARin = 1'b0; MDRin = 1'b0; tb_bus_en = 1'b0; mem.mem_ack = 1'b0;
        end
        if (d <= TO_CYC && is_read) exp_mdr = rd_val;
        if (d > TO_CYC) exp_err = 1'b1;
        checkOutput("req_cycles", 32'(count), 32'(exp_cycles));
        checkOutput("done_end", {31'b0, done}, (d <= TO_CYC) ? 32'd1 : 32'd0);
        checkOutput("err_end", {31'b0, err}, {31'b0, exp_err});
        checkOutput("req_end", {31'b0, mem.mem_req}, 32'd0);
        checkOutput("busy_end", {31'b0, busy}, 32'd0);
        checkOutput("addr_end", mem.mem_addr, exp_mar);
        @(negedge clk);
        checkOutput("done_one_cycle", {31'b0, done}, 32'd0);
        readMdr();
    endtask

    task automatic resetMidRead();
        Read = 1'b1;
        @(negedge clk);
        Read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_req", {31'b0, mem.mem_req}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_addr", mem.mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_mar = '0;
        exp_mdr = '0;
        exp_err = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_no_done", {31'b0, done}, 32'd0);
            checkOutput("rst_idle", {31'b0, busy}, 32'd0);
        end
        readMdr();
    endtask

    initial begin
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mem_req", {31'b0, mem.mem_req}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem.mem_we}, 32'd0);
        checkOutput("rst_flags", {29'b0, busy, done, err}, 32'd0);
        checkOutput("rst_mar", mem.mem_addr, 32'd0);
        readMdr();

        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        readMdr();

        doTransaction(1'b1, 1'b0, 3, 1'b0, 1'b0, '0, 32'h1234_5678);
        applyStimulus(1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0);
        doTransaction(1'b0, 1'b1, 1, 1'b0, 1'b0, '0, '0);
        doTransaction(1'b1, 1'b0, 99, 1'b0, 1'b0, '0, 32'hFFFF_0000);
        doTransaction(1'b1, 1'b0, 2, 1'b0, 1'b0, '0, 32'h0BAD_CAFE);
        doTransaction(1'b1, 1'b1, 4, 1'b1, 1'b0, 32'h0000_0040, 32'h7777_1111);
        doTransaction(1'b1, 1'b0, 5, 1'b0, 1'b1, 32'h5555_AAAA, 32'h9999_0001);
        resetMidRead();

        for (int i = 0; i < 30; i++) begin
            logic [31:0] v;
            bit rd, wr;
            v = $urandom;
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, v, $urandom_range(0, 3) == 0);
            rd = $urandom_range(0, 1) == 1;
            wr = !rd || ($urandom_range(0, 3) == 0);
            doTransaction(rd, wr, $urandom_range(1, TO_CYC + 3),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                          $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
